// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter with lane mux.
// Holds the FSM state enum, requester count and the rotating winner search.
package mux4_arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); first requester found wins.
   function automatic logic [1:0] rr_winner(input logic [N_REQ-1:0] req,
                                            input logic [1:0]       ptr);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = ptr;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/mux4_lane_sel.sv
// Combinational DW-wide 4:1 lane selector; drives zero whenever no grant is active.
module mux4_lane_sel
   import mux4_arb_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [N_REQ*DW-1:0] din,
   input  logic [1:0]          sel,
   input  logic                vld,
   output logic [DW-1:0]       dout
);

   logic [DW-1:0] lane [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane[gi] = din[gi*DW +: DW];
   end

   assign dout = vld ? lane[sel] : '0;

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin 4-requester arbiter with a mandatory bubble between grants and a lane mux.
// Optional grant-hold limit and to_pulse strobe are enabled by defining ARB_TIMEOUT_EN.
module mux4_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int DW       = 8,
   parameter int HOLD_MAX = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] din,
   output logic [N_REQ-1:0]    gnt,
   output logic [1:0]          sel,
   output logic [DW-1:0]       dout,
   output logic                dout_vld
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                to_pulse
`endif
);

   if (HOLD_MAX < 1) begin : g_hold_chk
      $error("mux4_arbiter: HOLD_MAX must be at least 1");
   end

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       win;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       to_pulse_q, to_pulse_d;
`endif

   assign win = rr_winner(req, ptr_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
      to_pulse_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (|req) begin
               state_d = BUSY;
               sel_d   = win;
               ptr_d   = win;
               gnt_d   = 4'b0001 << win;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end
         end
         BUSY: begin
            // Voluntary release takes precedence over a coincident forced release.
            if (!req[sel_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = IDLE;
               gnt_d      = '0;
               to_pulse_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
         to_pulse_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
         to_pulse_q <= to_pulse_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign sel      = sel_q;
   assign dout_vld = (state_q == BUSY);
`ifdef ARB_TIMEOUT_EN
   assign to_pulse = to_pulse_q;
`endif

   mux4_lane_sel #(
      .DW (DW)
   ) u_lane_sel (
      .din  (din),
      .sel  (sel_q),
      .vld  (dout_vld),
      .dout (dout)
   );

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed scoreboard bench for mux4_arbiter (DW=8, HOLD_MAX=16); honours ARB_TIMEOUT_EN.
module tb_mux4_arbiter;

   localparam int DW = 8;

   typedef struct {
      string      tag;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       chk_sel;
      logic       to;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [4*DW-1:0] din;
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          to_pulse;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mux4_arbiter #(
      .DW       (DW),
      .HOLD_MAX (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .din      (din),
      .gnt      (gnt),
      .sel      (sel),
      .dout     (dout),
      .dout_vld (dout_vld)
`ifdef ARB_TIMEOUT_EN
      ,
      .to_pulse (to_pulse)
`endif
   );

`ifndef ARB_TIMEOUT_EN
   assign to_pulse = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] lane_of(input logic [4*DW-1:0] d, input logic [1:0] s);
      return d[s*DW +: DW];
   endfunction

   // Drive one cycle of stimulus, push the expected post-edge result, then pop and compare.
   task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] es, input logic cs, input logic eto, input string tag);
      exp_t e;
      logic [DW-1:0] edout;
      rst_n = rn;
      req   = r;
      sb.push_back('{tag, eg, es, cs, eto});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      edout = (e.gnt != 4'b0) ? lane_of(din, e.sel) : '0;
      check({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
      check({e.tag, ".vld"}, 32'(dout_vld), 32'(e.gnt != 4'b0));
      check({e.tag, ".dout"}, 32'(dout), 32'(edout));
      if (e.chk_sel || e.gnt != 4'b0)
         check({e.tag, ".sel"}, 32'(sel), 32'(e.sel));
`ifdef ARB_TIMEOUT_EN
      check({e.tag, ".to"}, 32'(to_pulse), 32'(e.to));
`endif
      $display("step %-10s rst_n=%b req=%b gnt=%b sel=%0d vld=%b dout=%h to=%b",
               e.tag, rn, r, gnt, sel, dout_vld, dout, to_pulse);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0;
      din   = 32'hD4C3B2A1;
      #2;

      // Reset ignores requests
      step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0, "rst0");
      step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0, "rst1");

      // Single request
      step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0, "single");
      step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "single_rel");
      step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle");

      // Round robin from a fresh reset
      step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "rst2");
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 4'b1111, 4'b0001 << k, 2'(k), 1'b0, 1'b0, "rr_gnt");
         step(1'b1, 4'b0001 << k, 4'b0001 << k, 2'(k), 1'b0, 1'b0, "rr_hold");
         step(1'b1, ~(4'b0001 << k), 4'b0000, 2'd0, 1'b0, 1'b0, "rr_bubble");
      end
      step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0, "rr_again");
      step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel");

      // ptr=0: 1001 resolves to requester 3
      step(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b0, 1'b0, "rot3");
      step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rot3_rel");
      // Wrap: ptr=3, 1001 resolves to requester 0
      step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0, "wrap");
      step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_rel");

      // Reset mid-operation
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, "busy2");
      din = 32'h11223344;
      #1;
      check("dout_comb", 32'(dout), 32'h22);
      step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b1, 1'b0, "rst_mid");
      step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0, "post_rst");

      // Hold limit, from a fresh reset so requester 0 wins first
      step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "rst3");
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++)
         step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, 1'b0, "to_hold0");
      step(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, "to_force");
      step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b0, 1'b0, "to_next");
      for (int i = 0; i < 15; i++)
         step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b0, 1'b0, "to_hold1");
      // Voluntary release coinciding with the limit
      step(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "to_vol");
      step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0, "to_after");
`else
      for (int i = 0; i < 110; i++)
         step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, 1'b0, "no_to");
`endif

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
